// File: rtl/canv_pix_read_pkg.sv
// Shared graphics constants: bits-per-pixel encodings and default vram latency.
// Also provides the bpp normalisation used wherever pixels are unpacked.
package canv_pix_read_pkg;

  typedef logic [3:0] bpp_t;

  localparam bpp_t BPP_1 = 4'd1;
  localparam bpp_t BPP_2 = 4'd2;
  localparam bpp_t BPP_4 = 4'd4;
  localparam bpp_t BPP_8 = 4'd8;

  localparam int VRAM_LAT_DEF = 2;

  // Anything other than 1/2/4/8 bits per pixel falls back to 4.
  function automatic bpp_t normBpp(input bpp_t bpp);
    case (bpp)
      BPP_1, BPP_2, BPP_4, BPP_8: return bpp;
      default:                    return BPP_4;
    endcase
  endfunction

endpackage

// File: rtl/canv_pix_read_pix_select.sv
// Combinational pixel extractor: picks one packed pixel out of a vram word.
// Shared with the display path, so it holds no state.
module pix_select
  import canv_pix_read_pkg::*;
#(
  parameter int WORD  = 32,
  parameter int PIXW  = 7,
  parameter int COLRW = 8
) (
  input  logic [WORD-1:0]  word_i,
  input  logic [PIXW-1:0]  pixId_i,
  input  logic [3:0]       bpp_i,
  output logic [COLRW-1:0] cidx_o
);

  localparam int SHW = PIXW + 4;

  bpp_t            bppN;
  logic [SHW-1:0]  shAmt;
  logic [WORD-1:0] shifted;
  logic [WORD-1:0] mask;

  // Shift amounts past the word width naturally yield zero.
  always_comb begin
    bppN    = normBpp(bpp_i);
    shAmt   = SHW'(pixId_i) * SHW'(bppN);
    shifted = word_i >> shAmt;
    mask    = ~({WORD{1'b1}} << bppN);
    cidx_o  = COLRW'(shifted & mask);
  end

endmodule

// File: rtl/canv_pix_read.sv
// Single-pixel canvas reader: bounds check, linear index, vram fetch,
// then pixel extraction with a one-cycle valid strobe.
module canv_pix_read
  import canv_pix_read_pkg::*;
#(
  parameter int CORDW    = 16,
  parameter int WORD     = 32,
  parameter int ADDRW    = 14,
  parameter int SHIFTW   = 3,
  parameter int COLRW    = 8,
  parameter int VRAM_LAT = VRAM_LAT_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic signed [CORDW-1:0] x_i,
  input  logic signed [CORDW-1:0] y_i,
  input  logic [CORDW-1:0]        canv_w_i,
  input  logic [CORDW-1:0]        canv_h_i,
  input  logic [3:0]              canv_bpp_i,
  input  logic [ADDRW-1:0]        addr_base_i,
  input  logic [SHIFTW-1:0]       addr_shift_i,
  output logic [ADDRW-1:0]        vram_addr_o,
  input  logic [WORD-1:0]         vram_dout_i,
  output logic [COLRW-1:0]        cidx_o,
  output logic                    valid_o,
  output logic                    oob_o,
  output logic                    busy_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CALC = 3'd1;
  localparam logic [2:0] ADDR = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam int PIXW = (SHIFTW > 0) ? (1 << SHIFTW) - 1 : 1;
  localparam int IDXW = 2 * CORDW;
  localparam int CNTW = (VRAM_LAT > 1) ? $clog2(VRAM_LAT) : 1;

  logic [2:0]              state_q,    state_d;
  logic signed [CORDW-1:0] x_q,        x_d;
  logic signed [CORDW-1:0] y_q,        y_d;
  logic [CORDW-1:0]        w_q,        w_d;
  logic [CORDW-1:0]        h_q,        h_d;
  logic [3:0]              bpp_q,      bpp_d;
  logic [ADDRW-1:0]        base_q,     base_d;
  logic [SHIFTW-1:0]       shift_q,    shift_d;
  logic [IDXW-1:0]         index_q,    index_d;
  logic [PIXW-1:0]         pixId_q,    pixId_d;
  logic [CNTW-1:0]         cnt_q,      cnt_d;
  logic [ADDRW-1:0]        vramAddr_q, vramAddr_d;
  logic [COLRW-1:0]        cidx_q,     cidx_d;
  logic                    valid_q,    valid_d;
  logic                    oob_q,      oob_d;
  logic                    busy_q,     busy_d;

  logic                    outOfBounds;
  logic [COLRW-1:0]        pixCidx;

  pix_select #(
    .WORD  (WORD),
    .PIXW  (PIXW),
    .COLRW (COLRW)
  ) u_pix_select (
    .word_i  (vram_dout_i),
    .pixId_i (pixId_q),
    .bpp_i   (bpp_q),
    .cidx_o  (pixCidx)
  );

  // Negative coordinates are caught by sign bit before the unsigned compares.
  always_comb begin
    outOfBounds = x_q[CORDW-1] || y_q[CORDW-1] ||
                  ($unsigned(x_q) >= w_q) || ($unsigned(y_q) >= h_q);
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    bpp_d      = bpp_q;
    base_d     = base_q;
    shift_d    = shift_q;
    index_d    = index_q;
    pixId_d    = pixId_q;
    cnt_d      = cnt_q;
    vramAddr_d = vramAddr_q;
    cidx_d     = cidx_q;
    valid_d    = 1'b0;
    oob_d      = oob_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d     = x_i;
          y_d     = y_i;
          w_d     = canv_w_i;
          h_d     = canv_h_i;
          bpp_d   = canv_bpp_i;
          base_d  = addr_base_i;
          shift_d = addr_shift_i;
          oob_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        oob_d = outOfBounds;
        if (outOfBounds) begin
          state_d = DONE;
        end else begin
          index_d = IDXW'($unsigned(y_q)) * IDXW'(w_q) + IDXW'($unsigned(x_q));
          state_d = ADDR;
        end
      end
      ADDR: begin
        vramAddr_d = base_q + ADDRW'(index_q >> shift_q);
        pixId_d    = PIXW'(index_q) & ~({PIXW{1'b1}} << shift_q);
        cnt_d      = CNTW'(VRAM_LAT - 1);
        state_d    = (VRAM_LAT == 0) ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        cidx_d  = oob_q ? '0 : pixCidx;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      bpp_q      <= '0;
      base_q     <= '0;
      shift_q    <= '0;
      index_q    <= '0;
      pixId_q    <= '0;
      cnt_q      <= '0;
      vramAddr_q <= '0;
      cidx_q     <= '0;
      valid_q    <= 1'b0;
      oob_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      bpp_q      <= bpp_d;
      base_q     <= base_d;
      shift_q    <= shift_d;
      index_q    <= index_d;
      pixId_q    <= pixId_d;
      cnt_q      <= cnt_d;
      vramAddr_q <= vramAddr_d;
      cidx_q     <= cidx_d;
      valid_q    <= valid_d;
      oob_q      <= oob_d;
      busy_q     <= busy_d;
    end
  end

  assign vram_addr_o = vramAddr_q;
  assign cidx_o      = cidx_q;
  assign valid_o     = valid_q;
  assign oob_o       = oob_q;
  assign busy_o      = busy_q;

endmodule
